// File: rtl/alu_pipe_reg_pkg.sv
// Shared constants and helpers for the ALU result pipeline register.
package alu_pipe_reg_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 2;

    // Bits needed to count 0..depth valid stages.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/alu_pipe_stage.sv
// One pipeline slot: data word plus valid bit, loaded from upstream when advancing.
module alu_pipe_stage
    import alu_pipe_reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance,
    input  logic             flush,
    input  logic [WIDTH-1:0] up_data,
    input  logic             up_valid,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
        end else begin
            if (advance) begin
                data <= up_data;
            end
            // Flush wins over a concurrent load so nothing survives the discard.
            if (flush) begin
                valid <= 1'b0;
            end else if (advance) begin
                valid <= up_valid;
            end
        end
    end

endmodule

// File: rtl/alu_pipe_reg.sv
// Elastic DEPTH-stage register pipe for ALU results with bubble collapsing and flush.
module alu_pipe_reg
    import alu_pipe_reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         flush,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [occ_width(DEPTH)-1:0]  occupancy
);

    localparam int OW = occ_width(DEPTH);

    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [DEPTH-1:0] stage_valid;
    logic [DEPTH-1:0] advance;
    logic             in_xfer;
    logic             out_xfer;

    // A stage may move when it is empty or everything downstream of it moves.
    always_comb begin
        advance          = '0;
        advance[DEPTH-1] = !stage_valid[DEPTH-1] || out_ready;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            advance[k] = !stage_valid[k] || advance[k+1];
        end
    end

    assign in_ready  = rst_n && advance[0] && !flush;
    assign in_xfer   = in_valid && in_ready;
    assign out_data  = stage_data[DEPTH-1];
    assign out_valid = stage_valid[DEPTH-1];
    assign out_xfer  = out_valid && out_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] up_data;
        logic             up_valid;

        if (k == 0) begin : g_head
            assign up_data  = in_data;
            assign up_valid = in_xfer;
        end else begin : g_body
            assign up_data  = stage_data[k-1];
            assign up_valid = stage_valid[k-1];
        end

        alu_pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .advance (advance[k]),
            .flush   (flush),
            .up_data (up_data),
            .up_valid(up_valid),
            .data    (stage_data[k]),
            .valid   (stage_valid[k])
        );
    end

    // Occupancy tracks the valid bits by counting transfers at both ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else begin
            occupancy <= occupancy + OW'(in_xfer) - OW'(out_xfer);
        end
    end

endmodule

// File: tb/tb_alu_pipe_reg.sv
// Directed self-checking bench for alu_pipe_reg at WIDTH=32, DEPTH=3.
module tb_alu_pipe_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  occupancy;

    int checks = 0;
    int errors = 0;

    alu_pipe_reg #(
        .WIDTH(32),
        .DEPTH(3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .flush    (flush),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: run did not complete");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Loads three entries base, base+1, base+2 with the consumer stalled.
    task automatic fill3(input logic [31:0] base);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = base + 32'(i);
            tick;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
        #3;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL rst_occupancy got=%0d exp=0", occupancy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        tick; tick;
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got=%b exp=1", in_ready); end
        // Two entries, then asynchronous reset mid-cycle.
        in_valid = 1'b1; in_data = 32'h31; tick;
        in_data = 32'h32; tick;
        in_valid = 1'b0; tick;
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL pre_rst_occ got=%0d exp=2", occupancy); end
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h31) begin errors++; $display("FAIL pre_rst_out got=%b/%h exp=1/31", out_valid, out_data); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_rst_valid got=%b exp=0", out_valid); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL async_rst_occ got=%0d exp=0", occupancy); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL async_rst_data got=%h exp=0", out_data); end
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_streaming;
        logic exp_v;
        out_ready = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            if (e <= 4) begin
                in_valid = 1'b1;
                in_data  = 32'(e);
                #1;
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready e=%0d got=%b exp=1", e, in_ready); end
            end else begin
                in_valid = 1'b0;
            end
            tick;
            exp_v = (e >= 3 && e <= 6);
            checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL stream_valid e=%0d got=%b exp=%b", e, out_valid, exp_v); end
            if (exp_v) begin
                checks++; if (out_data !== 32'(e - 2)) begin errors++; $display("FAIL stream_data e=%0d got=%h exp=%h", e, out_data, 32'(e - 2)); end
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        logic [31:0] exp_q [4];
        int n;
        logic acc;
        exp_q[0] = 32'hA; exp_q[1] = 32'hB; exp_q[2] = 32'hC; exp_q[3] = 32'hD;
        fill3(32'hA);
        in_valid = 1'b1; in_data = 32'hD;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (occupancy !== 2'd3) begin errors++; $display("FAIL bp_occ got=%0d exp=3", occupancy); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
            checks++; if (out_data !== 32'hA) begin errors++; $display("FAIL bp_hold got=%h exp=a", out_data); end
            tick;
        end
        out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            acc = in_valid && in_ready;
            if (out_valid) begin
                checks++;
                if (n > 3) begin errors++; $display("FAIL bp_extra got=%h exp=none", out_data); end
                else if (out_data !== exp_q[n]) begin errors++; $display("FAIL bp_order n=%0d got=%h exp=%h", n, out_data, exp_q[n]); end
                n++;
            end
            tick;
            if (acc) in_valid = 1'b0;
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL bp_count got=%0d exp=4", n); end
        out_ready = 1'b0;
    endtask

    task automatic test_bubble;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h5; tick;
        in_valid = 1'b0; tick;
        in_valid = 1'b1; in_data = 32'h6; tick;
        in_valid = 1'b0;
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL bubble_occ got=%0d exp=2", occupancy); end
        tick;
        checks++; if (occupancy !== 2'd2 || out_data !== 32'h5) begin errors++; $display("FAIL bubble_hold got=%0d/%h exp=2/5", occupancy, out_data); end
        out_ready = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h5) begin errors++; $display("FAIL bubble_first got=%b/%h exp=1/5", out_valid, out_data); end
        tick;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h6) begin errors++; $display("FAIL bubble_adjacent got=%b/%h exp=1/6", out_valid, out_data); end
        tick;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bubble_empty got=%b exp=0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_flush;
        logic seen;
        fill3(32'h11);
        flush = 1'b1; in_valid = 1'b1; in_data = 32'h7;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
        tick;
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
        out_ready = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            tick;
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_dropped got=%b exp=0", seen); end
        // Flush coinciding with an output transfer still leaves the pipe empty.
        fill3(32'h41);
        out_ready = 1'b1; flush = 1'b1;
        tick;
        flush = 1'b0; out_ready = 1'b0;
        checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_ready got=%0d/%b exp=0/0", occupancy, out_valid); end
    endtask

    task automatic test_back_to_back;
        fill3(32'h21);
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h9;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_in_ready got=%b exp=1", in_ready); end
        tick;
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (occupancy !== 2'd3) begin errors++; $display("FAIL full_occ got=%0d exp=3", occupancy); end
        checks++; if (out_data !== 32'h22) begin errors++; $display("FAIL full_head got=%h exp=22", out_data); end
        out_ready = 1'b1;
        tick; tick;
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h9) begin errors++; $display("FAIL full_tail got=%b/%h exp=1/9", out_valid, out_data); end
        drain;
    endtask

    initial begin
        test_reset;
        test_streaming;
        drain;
        test_backpressure;
        drain;
        test_bubble;
        drain;
        test_flush;
        drain;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
